test_phase_sequencer: RTL

Synthesizable driver for the test-suite phase protocol: steps a consumer through suite setup, per-case setup/run/cleanup and suite cleanup, one phase at a time. It enforces a per-phase watchdog and tallies pass, fail and timeout results. It sits on the initiator side of the phase handshake, and a bench-side phase consumer or a hardware self-test block responds to it. It is used for on-target regression of designs whose test structure mirrors the simulation suites.

---
 rtl/test_phase_pkg.sv | 46 ++++
 rtl/phase_watchdog.sv | 30 +++
 rtl/test_phase_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/test_phase_pkg.sv
// Shared types for the test-phase sequencer: phase codes, FSM states and
// phase-ordering helpers.
package test_phase_pkg;

  typedef enum logic [2:0] {
    SUITE_SETUP   = 3'd0,
    CASE_SETUP    = 3'd1,
    CASE_RUN      = 3'd2,
    CASE_CLEANUP  = 3'd3,
    SUITE_CLEANUP = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUITE_SETUP,
    ST_CASE_SETUP,
    ST_CASE_RUN,
    ST_CASE_CLEANUP,
    ST_SUITE_CLEANUP,
    ST_GAP,
    ST_FINISH
  } state_e;

  // Phase that follows a normally completed phase.
  function automatic phase_e next_phase(phase_e cur, int unsigned idx,
                                        int unsigned num_cases);
    case (cur)
      SUITE_SETUP:  next_phase = (num_cases == 0) ? SUITE_CLEANUP : CASE_SETUP;
      CASE_SETUP:   next_phase = CASE_RUN;
      CASE_RUN:     next_phase = CASE_CLEANUP;
      CASE_CLEANUP: next_phase = (idx + 1 >= num_cases) ? SUITE_CLEANUP : CASE_SETUP;
      default:      next_phase = SUITE_CLEANUP;
    endcase
  endfunction

  function automatic state_e phase_state(phase_e p);
    case (p)
      SUITE_SETUP:  phase_state = ST_SUITE_SETUP;
      CASE_SETUP:   phase_state = ST_CASE_SETUP;
      CASE_RUN:     phase_state = ST_CASE_RUN;
      CASE_CLEANUP: phase_state = ST_CASE_CLEANUP;
      default:      phase_state = ST_SUITE_CLEANUP;
    endcase
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: reloaded when a phase opens, expires on the
// TIMEOUT_CYCLES-th enabled cycle after the reload.
module phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/test_phase_sequencer.sv
// Initiator for the test-suite phase handshake: sequences suite/case phases,
// applies a per-phase watchdog and tallies pass/fail/timeout results.
module test_phase_sequencer
  import test_phase_pkg::*;
#(
  parameter int unsigned NUM_CASES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = (NUM_CASES > 0) ? $clog2(NUM_CASES + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             phase_valid,
  output phase_e           phase,
  output logic [CNT_W-1:0] case_idx,
  input  logic             phase_done,
  input  logic             phase_pass,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] n_pass,
  output logic [CNT_W-1:0] n_fail,
  output logic [CNT_W-1:0] n_timeout
);

  state_e           state, state_n;
  phase_e           phase_n;
  logic [CNT_W-1:0] case_idx_n, n_pass_n, n_fail_n, n_timeout_n;
  logic             phase_valid_n, busy_n, done_n, timed_out_n;
  logic             wd_expire, wd_load;

  // Saturating so that suite-level timeouts on top of per-case ones never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign wd_load = phase_valid_n && !phase_valid;

  phase_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .enable (phase_valid),
    .expire (wd_expire)
  );

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    case_idx_n  = case_idx;
    n_pass_n    = n_pass;
    n_fail_n    = n_fail;
    n_timeout_n = n_timeout;
    busy_n      = busy;
    done_n      = done;
    timed_out_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_SUITE_SETUP;
          phase_n     = SUITE_SETUP;
          case_idx_n  = '0;
          n_pass_n    = '0;
          n_fail_n    = '0;
          n_timeout_n = '0;
          busy_n      = 1'b1;
          done_n      = 1'b0;
        end
      end
      ST_GAP: state_n = phase_state(phase);
      ST_FINISH: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: begin
        // phase_done has priority over a same-cycle watchdog expiry.
        if (phase_done) begin
          if (phase == CASE_RUN) begin
            if (phase_pass) n_pass_n = sat_inc(n_pass);
            else            n_fail_n = sat_inc(n_fail);
          end
          if (phase == SUITE_CLEANUP) begin
            state_n = ST_FINISH;
          end else begin
            state_n = ST_GAP;
            phase_n = next_phase(phase, int'(case_idx), NUM_CASES);
            if (phase == CASE_CLEANUP && phase_n == CASE_SETUP)
              case_idx_n = case_idx + CNT_W'(1);
          end
        end else if (wd_expire) begin
          timed_out_n = 1'b1;
          n_timeout_n = sat_inc(n_timeout);
          case (phase)
            CASE_RUN: begin
              n_fail_n = sat_inc(n_fail);
              state_n  = ST_GAP;
              phase_n  = CASE_CLEANUP;
            end
            SUITE_CLEANUP: state_n = ST_FINISH;
            default: begin
              if (phase == CASE_SETUP) n_fail_n = sat_inc(n_fail);
              state_n = ST_GAP;
              phase_n = SUITE_CLEANUP;
            end
          endcase
        end
      end
    endcase

    phase_valid_n = state_n inside {ST_SUITE_SETUP, ST_CASE_SETUP, ST_CASE_RUN,
                                    ST_CASE_CLEANUP, ST_SUITE_CLEANUP};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase       <= SUITE_SETUP;
      case_idx    <= '0;
      n_pass      <= '0;
      n_fail      <= '0;
      n_timeout   <= '0;
      phase_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      case_idx    <= case_idx_n;
      n_pass      <= n_pass_n;
      n_fail      <= n_fail_n;
      n_timeout   <= n_timeout_n;
      phase_valid <= phase_valid_n;
      busy        <= busy_n;
      done        <= done_n;
      timed_out   <= timed_out_n;
    end
  end

endmodule
